// File: rtl/vga_line_fetcher.sv
// Scanline fetcher: fills one of two ping-pong line buffers from the framebuffer
// while the other buffer streams RGB555 pixels to the VGA DAC on the pixel strobe.
module vga_line_fetcher #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned ADDR_W   = 19
) (
   input  logic              input_clk,
   input  logic              rst_n,
   input  logic              line_start,
   input  logic [8:0]        next_line,
   input  logic              next_active,
   input  logic              pix_en,
   input  logic [9:0]        hpos,
   input  logic              blank,
   input  logic [ADDR_W-1:0] fb_base,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic [4:0]        vr,
   output logic [4:0]        vg,
   output logic [4:0]        vb,
   output logic              underrun,
   input  logic              underrun_clr
);

   localparam int unsigned CntW = $clog2(H_ACTIVE + 1);
   localparam int unsigned IdxW = $clog2(H_ACTIVE);

   typedef enum logic [0:0] {StIdle, StFetch} state_e;

   state_e                     state_q, state_d;
   logic                       disp_sel_q, disp_sel_d;
   logic [1:0][CntW-1:0]       fcnt_q, fcnt_d;
   logic [CntW-1:0]            idx_q, idx_d;
   logic [ADDR_W-1:0]          base_q, base_d;
   logic                       underrun_q, underrun_d;
   logic [14:0]                pix_q, pix_d;

   logic [14:0]                line_buf [2][H_ACTIVE];

   logic                       fetch_sel;
   logic                       wr_en;
   logic                       last_word;
   logic                       abort;
   logic                       show;
   logic [14:0]                rd_word;
   logic                       unused_rdata_msb;

   assign fetch_sel        = ~disp_sel_q;
   assign wr_en            = (state_q == StFetch) && mem_ack;
   assign last_word        = (idx_q == CntW'(H_ACTIVE - 1));
   // A fetch whose final word lands on the line_start cycle is complete, not aborted.
   assign abort            = line_start && (state_q == StFetch) && !(wr_en && last_word);
   assign unused_rdata_msb = mem_rdata[15];

   // ---------------------------------------------------------------- fetch FSM
   always_ff @(posedge input_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (line_start && next_active) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (line_start) begin
               state_d = next_active ? StFetch : StIdle;
            end else if (wr_en && last_word) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_req = (state_q == StFetch);
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      disp_sel_d = disp_sel_q;
      fcnt_d     = fcnt_q;
      idx_d      = idx_q;
      base_d     = base_q;

      if (wr_en) begin
         idx_d            = idx_q + 1'b1;
         fcnt_d[fetch_sel] = fcnt_q[fetch_sel] + 1'b1;
      end

      // The swap overrides the index but not the old fetch buffer's count.
      if (line_start) begin
         disp_sel_d         = ~disp_sel_q;
         base_d             = fb_base + ADDR_W'(next_line) * ADDR_W'(H_ACTIVE);
         idx_d              = '0;
         fcnt_d[disp_sel_q] = '0;
      end
   end

   always_comb begin
      underrun_d = abort | (underrun_q & ~underrun_clr);
   end

   always_comb begin
      rd_word = line_buf[disp_sel_q][hpos[IdxW-1:0]];
      show    = !blank && (CntW'(hpos) < fcnt_q[disp_sel_q]);
      pix_d   = pix_q;
      if (pix_en) begin
         pix_d = show ? rd_word : '0;
      end
   end

   always_ff @(posedge input_clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_sel_q <= 1'b0;
         fcnt_q     <= '0;
         idx_q      <= '0;
         base_q     <= '0;
         underrun_q <= 1'b0;
         pix_q      <= '0;
      end else begin
         disp_sel_q <= disp_sel_d;
         fcnt_q     <= fcnt_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         underrun_q <= underrun_d;
         pix_q      <= pix_d;
      end
   end

   // Buffer storage has no reset; an empty fill count keeps stale words hidden.
   always_ff @(posedge input_clk) begin
      if (wr_en) begin
         line_buf[fetch_sel][idx_q[IdxW-1:0]] <= mem_rdata[14:0];
      end
   end

   assign mem_addr = base_q + ADDR_W'(idx_q);
   assign vr       = pix_q[14:10];
   assign vg       = pix_q[9:5];
   assign vb       = pix_q[4:0];
   assign underrun = underrun_q;

endmodule

// File: doc/vga_line_fetcher.md
# vga_line_fetcher

Scanline fetch and pixel-output stage that sits between the framebuffer memory port and the VGA DAC pins (vr/vg/vb). It fetches the next visible line from memory during the current line into a ping-pong pair of 640-pixel line buffers. It then streams the current line to the DAC on the timing generator's pixel strobe. The timing generator (640x400@70Hz, 800x450 total, pixel = input_clk/2) provides line_start, hpos and blank.

## Interface
- H_ACTIVE, 640, visible pixels per line (buffer depth)
- ADDR_W, 19, memory word-address width
- input_clk  in  1  system clock (pixel rate is half of it)
- rst_n  in  1  reset, asynchronous, active-low
- line_start  in  1  one-clock pulse at start of horizontal blank (hpos==640)
- next_line  in  9  line number to fetch, valid with line_start
- next_active  in  1  next line is visible (<400), valid with line_start
- pix_en  in  1  pixel strobe, one clock per pixel
- hpos  in  10  current pixel column
- blank  in  1  high outside the active area
- fb_base  in  ADDR_W  framebuffer base word address, sampled at line_start
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read word address
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  16  RGB555 pixel: [14:10] R, [9:5] G, [4:0] B; bit 15 ignored
- vr, vg, vb  out  5 each  registered DAC outputs
- underrun  out  1  sticky: a fetch was incomplete at line_start
- underrun_clr  in  1  clears underrun (set wins if simultaneous)

## Operation
- Two buffers, each H_ACTIVE x 15 bits, with a per-buffer fill count fcnt[0..1] (0..640).
- disp_sel selects the display buffer; the fetch always targets the other buffer, !disp_sel.
- On line_start:
  - toggle disp_sel
  - latch base = fb_base + next_line*H_ACTIVE, computed mod 2^ADDR_W
  - reset the fetch index to 0 and set fcnt of the new fetch buffer to 0
  - if next_active, enter FETCH; else go IDLE (the buffer stays empty and displays black)
- Fetch FSM states are IDLE and FETCH.
- FETCH:
  - mem_req=1, mem_addr=base+index; the address is held stable until mem_ack.
  - On mem_ack, write mem_rdata[14:0] to buf[!disp_sel][index], then increment index and fcnt.
  - The next address appears the following cycle. mem_req stays high with no idle cycle.
  - After the write at index==H_ACTIVE-1, go to IDLE and deassert mem_req the next cycle.
- Display path, on pix_en:
  - If blank, or hpos >= fcnt[disp_sel], the output is 0/0/0.
  - Otherwise the output is buf[disp_sel][hpos] split into R/G/B.
  - Outputs hold their value between strobes.
- Underrun: if line_start arrives while in FETCH, the fetch is aborted and underrun is set.
  - The aborted buffer becomes the display buffer with its partial fcnt, so the pixels at and beyond fcnt show black.
  - A new fetch starts as above.
- A mem_ack in the same cycle as line_start is accepted and written to the old fetch buffer (before the swap). That word counts toward its fcnt.
- mem_req may drop without an ack only on abort. The memory must only ack while mem_req is high.

## Timing
- Reset values:
  - mem_req=0, mem_addr=0
  - vr=vg=vb=0, underrun=0
  - FSM=IDLE, disp_sel=0, both fcnt=0, index=0
  - Buffer contents are undefined, but are never displayed because fcnt=0.
- mem_req rises 1 clock after line_start (when next_active).
- Pixel latency: vr/vg/vb update on the clock edge after the pix_en cycle, i.e. 1 clock. The timing generator compensates for this.
- Budget: 640 acks per 1600 clocks, an average of ≤2.5 clocks per word. A zero-wait memory (ack the same cycle as req) completes in 640 clocks.
- Reset asserted mid-fetch drops mem_req asynchronously, and all state returns to its reset values.
- Buffer read/write collision is impossible: the read and write ports always target different buffers.

## Test plan
- Reset check: hold rst_n=0 and toggle clocks -> mem_req=0 and RGB=0; release reset, then line_start with next_active=0 -> no mem_req, RGB stays 0 across a full line.
- Zero-wait fetch: fb_base=0, next_line=5, memory returns data=address -> mem_addr sweeps 3200..3839 in 640 consecutive clocks. On the next line, pixel hpos=10 outputs 3210[14:0] split into R/G/B, 1 clock after pix_en.
- Wait states: memory acks 2 clocks after each req -> the fetch completes in 1920 clocks... → too slow. With a 1-clock delay (1280 clocks) the fetch completes, underrun stays 0, and a full line is displayed correctly.
- Underrun: acks every 4th clock -> at the next line_start, underrun=1 and fcnt=400. On the displayed line, hpos 0..399 show data and hpos 400..639 show 0. underrun_clr then clears the flag.
- Simultaneous events: an ack coincides with line_start -> that word is written, and the next mem_addr is the new line's base. Asserting underrun_clr on the same cycle as a new underrun leaves underrun=1.
- Address wrap: fb_base=2^19-100, next_line=0 -> mem_addr wraps from 524287 to 0 at index 100.
